// File: rtl/sysarr_pkg.sv
// Shared constants and helpers for the systolic-array blocks.
//   DATA_BW_DEF / WEIGHT_BW_DEF / NUM_PE_DEF / ACC_BW_DEF : default widths and row length
//   psum_bw(d,w,n) : chain width that holds an n-term sum of d x w bit signed products
//   sat_s(x,bw)    : clamp a signed 64-bit value to the signed range of a bw-bit word
package sysarr_pkg;
  localparam int DATA_BW_DEF   = 8;
  localparam int WEIGHT_BW_DEF = 8;
  localparam int NUM_PE_DEF    = 8;
  localparam int ACC_BW_DEF    = 24;

  function automatic int psum_bw(input int d, input int w, input int n);
    return d + w + $clog2(n);
  endfunction

  function automatic logic signed [63:0] sat_s(input logic signed [63:0] x, input int bw);
    logic signed [63:0] mx, mn;
    mx = (64'sd1 <<< (bw - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    if (x > mx) return mx;
    if (x < mn) return mn;
    return x;
  endfunction
endpackage

// File: rtl/pe_mac_cell.sv
// One weight-stationary MAC stage of the row.
//   clk, rstn       : clock, async active-low reset
//   en_i            : pipeline advance (0 = hold skew and psum registers)
//   a_i             : aligned activation for this stage; delayed SKEW cycles internally
//   w_ld_valid_i    : write w_ld_data_i into the shadow weight
//   w_ld_data_i     : new shadow weight
//   w_swap_i        : copy shadow -> active weight
//   psum_i / psum_o : partial sum from the left / registered partial sum to the right
module pe_mac_cell import sysarr_pkg::*; #(
  parameter int DATA_BW   = DATA_BW_DEF,
  parameter int WEIGHT_BW = WEIGHT_BW_DEF,
  parameter int PSUM_BW   = psum_bw(DATA_BW_DEF, WEIGHT_BW_DEF, NUM_PE_DEF),
  parameter int SKEW      = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en_i,
  input  logic [DATA_BW-1:0]   a_i,
  input  logic                 w_ld_valid_i,
  input  logic [WEIGHT_BW-1:0] w_ld_data_i,
  input  logic                 w_swap_i,
  input  logic [PSUM_BW-1:0]   psum_i,
  output logic [PSUM_BW-1:0]   psum_o
);
  logic [DATA_BW-1:0]   a_skw;
  logic [WEIGHT_BW-1:0] w_sh_q, w_act_q;
  logic [PSUM_BW-1:0]   a_x, w_x, prod, psum_q;

  generate
    if (SKEW == 0) begin : g_noskew
      assign a_skw = a_i;
    end else begin : g_skew
      logic [SKEW-1:0][DATA_BW-1:0] skew_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) skew_q <= '0;
        else if (en_i) begin
          skew_q[0] <= a_i;
          for (int k = 1; k < SKEW; k++) skew_q[k] <= skew_q[k-1];
        end
      end
      assign a_skw = skew_q[SKEW-1];
    end
  endgenerate

  // shadow loads are independent of the stall; the active copy only changes on swap
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_sh_q  <= '0;
      w_act_q <= '0;
    end else begin
      if (w_ld_valid_i) w_sh_q  <= w_ld_data_i;
      if (w_swap_i)     w_act_q <= w_sh_q;
    end
  end

  // operands sign-extended to chain width; the low PSUM_BW bits of the product are exact
  assign a_x  = {{(PSUM_BW-DATA_BW){a_skw[DATA_BW-1]}}, a_skw};
  assign w_x  = {{(PSUM_BW-WEIGHT_BW){w_act_q[WEIGHT_BW-1]}}, w_act_q};
  assign prod = a_x * w_x;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     psum_q <= '0;
    else if (en_i) psum_q <= psum_i + prod;
  end

  assign psum_o = psum_q;
endmodule

// File: rtl/pe_row_ws.sv
// Weight-stationary systolic row: NUM_PE chained MAC cells, internal input skew,
// valid/ready with a global stall, double-buffered weights and an optional K-tile accumulator.
//   clk, rstn              : clock, async active-low reset
//   w_ld_valid, w_ld_data  : shadow weight write (PE0 in MSBs)
//   w_swap_req, w_swap_ack : level request for shadow->active copy / 1-cycle ack
//   in_valid, in_ready     : input handshake; din aligned, PE0 in MSBs
//   in_first, in_last      : K-tile markers (accumulator clear / emit)
//   out_valid, out_ready   : output handshake
//   result                 : signed dot product, accumulated and saturated when ACC_EN=1
module pe_row_ws import sysarr_pkg::*; #(
  parameter int DATA_BW   = DATA_BW_DEF,
  parameter int WEIGHT_BW = WEIGHT_BW_DEF,
  parameter int NUM_PE    = NUM_PE_DEF,
  parameter int PSUM_BW   = psum_bw(DATA_BW, WEIGHT_BW, NUM_PE),
  parameter int ACC_EN    = 1,
  parameter int ACC_BW    = ACC_BW_DEF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        w_ld_valid,
  input  logic [NUM_PE*WEIGHT_BW-1:0] w_ld_data,
  input  logic                        w_swap_req,
  output logic                        w_swap_ack,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_PE*DATA_BW-1:0]   din,
  input  logic                        in_first,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_BW-1:0]           result
);
  logic                       en, accept, swap_do, pipe_empty, acc_part, swap_ack_q;
  logic [NUM_PE-1:0]          vld_pipe;   // bit k marks a valid wavefront in psum of PE k
  logic [NUM_PE:0][PSUM_BW-1:0] chain;
  logic [PSUM_BW-1:0]         psum_out;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en && !(w_swap_req && !swap_ack_q);
  assign accept   = in_valid && in_ready;
  assign chain[0] = '0;
  assign psum_out = chain[NUM_PE];

  generate
    for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
      pe_mac_cell #(
        .DATA_BW(DATA_BW), .WEIGHT_BW(WEIGHT_BW), .PSUM_BW(PSUM_BW), .SKEW(i)
      ) u_pe (
        .clk(clk), .rstn(rstn), .en_i(en),
        .a_i(din[(NUM_PE-1-i)*DATA_BW +: DATA_BW]),
        .w_ld_valid_i(w_ld_valid),
        .w_ld_data_i(w_ld_data[(NUM_PE-1-i)*WEIGHT_BW +: WEIGHT_BW]),
        .w_swap_i(swap_do),
        .psum_i(chain[i]), .psum_o(chain[i+1])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   vld_pipe <= '0;
    else if (en) vld_pipe <= {vld_pipe[NUM_PE-2:0], accept};
  end

  // swap only with nothing in flight and no half-built K-tile sum; the ack gap
  // keeps a held request from swapping twice
  assign pipe_empty = !(|vld_pipe) && !out_valid && !acc_part;
  assign swap_do    = w_swap_req && !swap_ack_q && pipe_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) swap_ack_q <= 1'b0;
    else       swap_ack_q <= swap_do;
  end
  assign w_swap_ack = swap_ack_q;

  generate
    if (ACC_EN != 0) begin : g_acc
      logic [NUM_PE-1:0]        first_pipe, last_pipe;
      logic signed [ACC_BW-1:0] acc_q, acc_d;
      logic                     ov_q, part_q;
      logic signed [63:0]       sum64;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          first_pipe <= '0;
          last_pipe  <= '0;
        end else if (en) begin
          first_pipe <= {first_pipe[NUM_PE-2:0], in_first};
          last_pipe  <= {last_pipe[NUM_PE-2:0], in_last};
        end
      end

      assign sum64 = 64'(acc_q) + 64'($signed(psum_out));
      assign acc_d = first_pipe[NUM_PE-1] ? ACC_BW'($signed(psum_out))
                                          : ACC_BW'(sat_s(sum64, ACC_BW));

      // en=1 means any pending result is being taken this cycle, so ov_q may drop
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          acc_q  <= '0;
          ov_q   <= 1'b0;
          part_q <= 1'b0;
        end else if (en) begin
          ov_q <= 1'b0;
          if (vld_pipe[NUM_PE-1]) begin
            acc_q  <= acc_d;
            ov_q   <= last_pipe[NUM_PE-1];
            part_q <= !last_pipe[NUM_PE-1];
          end
        end
      end

      assign out_valid = ov_q;
      assign result    = acc_q;
      assign acc_part  = part_q;
    end else begin : g_dir
      assign out_valid = vld_pipe[NUM_PE-1];
      assign result    = ACC_BW'($signed(psum_out));
      assign acc_part  = 1'b0;
    end
  endgenerate
endmodule
